// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// instr_sequencer_pkg : ISA constants, state encoding and flag helper.
// Revision: 1.0
// ============================================================================
package instr_sequencer_pkg;

  localparam int unsigned ISA_FLAGS_W = 6;

  typedef enum logic [1:0] {
    S_FETCH_OP  = 2'd0,
    S_FETCH_ARG = 2'd1,
    S_EXEC      = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_ADDI = 8'h04;
  localparam logic [7:0] OP_SUB  = 8'h05;
  localparam logic [7:0] OP_AND  = 8'h06;
  localparam logic [7:0] OP_OR   = 8'h07;
  localparam logic [7:0] OP_XOR  = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h09;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam int unsigned FLAG_ZSRC_HI  = 0;
  localparam int unsigned FLAG_ZSRC_LO  = 1;
  localparam int unsigned FLAG_B_FROM_Y = 2;
  localparam int unsigned FLAG_Z_WR     = 3;
  localparam int unsigned FLAG_X_RD     = 4;
  localparam int unsigned FLAG_Y_RD     = 5;

  localparam logic [1:0] ZSRC_NONE   = 2'd0;
  localparam logic [1:0] ZSRC_I2     = 2'd1;
  localparam logic [1:0] ZSRC_X      = 2'd2;
  localparam logic [1:0] ZSRC_RESULT = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // Index 0 of the result is the MSB of the z-source field.
  function automatic logic [0:ISA_FLAGS_W-1] mk_flags(
    input logic [1:0] zsrc,
    input logic       b_from_y,
    input logic       z_wr,
    input logic       x_rd,
    input logic       y_rd
  );
    return {zsrc, b_from_y, z_wr, x_rd, y_rd};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_opcode_decode.sv
`default_nettype none
// ============================================================================
// instr_sequencer_opcode_decode : combinational opcode -> control decode.
// Revision: 1.0
// ============================================================================
module instr_sequencer_opcode_decode
  import instr_sequencer_pkg::*;
(
  input  logic [7:0]               opcode_i,
  output logic [1:0]               argc_o,
  output logic [0:ISA_FLAGS_W-1]   flags_o,
  output logic [2:0]               alu_op_o,
  output logic                     is_jmp_o,
  output logic                     is_halt_o,
  output logic                     illegal_o
);

  always_comb begin
    argc_o    = 2'd0;
    flags_o   = '0;
    alu_op_o  = ALU_ADD;
    is_jmp_o  = 1'b0;
    is_halt_o = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_NOP:  ;
      OP_LDI: begin
        argc_o  = 2'd2;
        flags_o = mk_flags(ZSRC_I2, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      OP_MOV: begin
        argc_o  = 2'd2;
        flags_o = mk_flags(ZSRC_X, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        argc_o  = 2'd3;
        flags_o = mk_flags(ZSRC_RESULT, 1'b1, 1'b1, 1'b1, 1'b1);
        case (opcode_i)
          OP_SUB:  alu_op_o = ALU_SUB;
          OP_AND:  alu_op_o = ALU_AND;
          OP_OR:   alu_op_o = ALU_OR;
          OP_XOR:  alu_op_o = ALU_XOR;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        argc_o  = 2'd3;
        flags_o = mk_flags(ZSRC_RESULT, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      OP_JMP: begin
        argc_o   = 2'd1;
        is_jmp_o = 1'b1;
      end
      OP_HALT: is_halt_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// instr_sequencer : fetch/decode sequencer driving the datapath router.
// Revision: 1.0
// ============================================================================
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int W       = 8,
  parameter int AW      = 8,
  parameter int FLAGS_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_rd,
  input  logic [W-1:0]         mem_data,
  input  logic                 mem_ready,
  output logic [0:FLAGS_W-1]   flags,
  output logic [W-1:0]         i1,
  output logic [W-1:0]         i2,
  output logic [W-1:0]         i3,
  output logic [2:0]           alu_op,
  output logic                 exec_valid,
  output logic                 halted,
  output logic                 illegal
);

  state_t               state_q;
  logic [AW-1:0]        pc_q;
  logic [7:0]           opcode_q;
  logic [1:0]           arg_idx_q;
  logic [W-1:0]         i1_q, i2_q, i3_q;
  logic [0:FLAGS_W-1]   flags_q;
  logic [2:0]           alu_op_q;
  logic                 exec_valid_q, halted_q, illegal_q;

  logic [7:0]               dec_opcode;
  logic [1:0]               dec_argc;
  logic [0:ISA_FLAGS_W-1]   dec_flags;
  logic [2:0]               dec_alu_op;
  logic                     dec_is_jmp, dec_is_halt, dec_illegal;
  logic                     enter_exec;

  // The opcode byte is decoded straight off the bus so a zero-argument
  // instruction can enter EXEC on the same edge that fetched it.
  assign dec_opcode = (state_q == S_FETCH_OP) ? mem_data[7:0] : opcode_q;

  instr_sequencer_opcode_decode u_decode (
    .opcode_i  (dec_opcode),
    .argc_o    (dec_argc),
    .flags_o   (dec_flags),
    .alu_op_o  (dec_alu_op),
    .is_jmp_o  (dec_is_jmp),
    .is_halt_o (dec_is_halt),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    enter_exec = 1'b0;
    if (mem_ready) begin
      if (state_q == S_FETCH_OP)
        enter_exec = (dec_argc == 2'd0);
      else if (state_q == S_FETCH_ARG)
        enter_exec = (arg_idx_q == (dec_argc - 2'd1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH_OP;
      pc_q         <= '0;
      opcode_q     <= '0;
      arg_idx_q    <= '0;
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      flags_q      <= '0;
      alu_op_q     <= '0;
      exec_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH_OP: begin
          if (mem_ready) begin
            opcode_q  <= mem_data[7:0];
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            pc_q      <= pc_q + 1'b1;
            arg_idx_q <= '0;
            state_q   <= (dec_argc == 2'd0) ? S_EXEC : S_FETCH_ARG;
          end
        end
        S_FETCH_ARG: begin
          if (mem_ready) begin
            case (arg_idx_q)
              2'd0:    i1_q <= mem_data;
              2'd1:    i2_q <= mem_data;
              default: i3_q <= mem_data;
            endcase
            pc_q <= pc_q + 1'b1;
            if (enter_exec) state_q   <= S_EXEC;
            else            arg_idx_q <= arg_idx_q + 2'd1;
          end
        end
        S_EXEC: begin
          flags_q      <= '0;
          alu_op_q     <= '0;
          exec_valid_q <= 1'b0;
          if (dec_is_jmp) pc_q <= AW'(i1_q);
          if (dec_is_halt || dec_illegal) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= S_FETCH_OP;
          end
        end
        default: ;
      endcase

      if (enter_exec) begin
        flags_q      <= FLAGS_W'(dec_flags);
        alu_op_q     <= dec_alu_op;
        exec_valid_q <= 1'b1;
        illegal_q    <= illegal_q | dec_illegal;
      end
    end
  end

  assign mem_rd     = rst_n && ((state_q == S_FETCH_OP) || (state_q == S_FETCH_ARG));
  assign mem_addr   = pc_q;
  assign flags      = flags_q;
  assign i1         = i1_q;
  assign i2         = i2_q;
  assign i3         = i3_q;
  assign alu_op     = alu_op_q;
  assign exec_valid = exec_valid_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// tb_instr_sequencer : vector table plus scoreboard of expected EXEC cycles.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       mem_ready = 1'b0;
  logic [0:5] flags;
  logic [7:0] i1, i2, i3;
  logic [2:0] alu_op;
  logic       exec_valid, halted, illegal;

  always #5 clk = ~clk;

  instr_sequencer #(.W(8), .AW(8), .FLAGS_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .flags      (flags),
    .i1         (i1),
    .i2         (i2),
    .i3         (i3),
    .alu_op     (alu_op),
    .exec_valid (exec_valid),
    .halted     (halted),
    .illegal    (illegal)
  );

  logic [7:0] prog [0:255];
  int         wait_n = 0;
  int         wcnt = 0;
  logic       force_ready = 1'b0;

  // Garbage on the bus while not ready must never be consumed.
  assign mem_data = mem_ready ? prog[mem_addr] : 8'hA5;

  always @(negedge clk) begin
    if (force_ready) mem_ready = 1'b1;
    else if (!mem_rd) begin mem_ready = 1'b0; wcnt = 0; end
    else if (wcnt >= wait_n) begin mem_ready = 1'b1; wcnt = 0; end
    else begin mem_ready = 1'b0; wcnt++; end
  end

  typedef struct {
    logic [5:0] fl;
    logic [2:0] alu;
    logic [7:0] a1, a2, a3;
    logic [7:0] addr;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [31:0] bytes;
    int          len;
    int          wn;
    logic [5:0]  fl;
    logic [2:0]  alu;
    logic [7:0]  a1, a2, a3;
  } vec_t;

  exp_t sb [$];
  vec_t vecs [9];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] fl, input logic [2:0] alu, input logic [7:0] a1,
                      input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] addr,
                      input logic ill);
    exp_t e;
    e.fl = fl; e.alu = alu; e.a1 = a1; e.a2 = a2; e.a3 = a3; e.addr = addr; e.ill = ill;
    sb.push_back(e);
  endtask

  logic       m_stall;
  logic [7:0] m_a0;
  always @(posedge clk) begin
    m_stall = rst_n && mem_rd && !mem_ready;
    m_a0    = mem_addr;
    #1;
    if (rst_n) begin
      if (m_stall) begin
        chk("addr_hold", mem_addr, m_a0);
        chk("rd_hold", mem_rd, 1);
      end
      if (exec_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_exec: got exec at addr %0h want none", mem_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("exec_flags", flags, e.fl);
          chk("exec_alu", alu_op, e.alu);
          chk("exec_i1", i1, e.a1);
          chk("exec_i2", i2, e.a2);
          chk("exec_i3", i3, e.a3);
          chk("exec_pc", mem_addr, e.addr);
          chk("exec_illegal", illegal, e.ill);
        end
      end else begin
        chk("idle_flags", flags, 0);
      end
      if (halted) chk("halt_rd", mem_rd, 0);
    end
  end

  task automatic clear_prog();
    for (int k = 0; k < 256; k++) prog[k] = 8'hFF;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    release_reset();
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 400) begin
      @(posedge clk); #2; n++;
    end
    chk({"halt_reached_", name}, halted, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h00000000, 1, 0, 6'b000000, 3'd0, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{32'h01035A00, 3, 1, 6'b010100, 3'd0, 8'h03, 8'h5A, 8'h00};
    vecs[2] = '{32'h02070900, 3, 0, 6'b100110, 3'd0, 8'h07, 8'h09, 8'h00};
    vecs[3] = '{32'h03010204, 4, 2, 6'b111111, 3'd0, 8'h01, 8'h02, 8'h04};
    vecs[4] = '{32'h04112233, 4, 0, 6'b110110, 3'd0, 8'h11, 8'h22, 8'h33};
    vecs[5] = '{32'h05AABBCC, 4, 1, 6'b111111, 3'd1, 8'hAA, 8'hBB, 8'hCC};
    vecs[6] = '{32'h0601807F, 4, 0, 6'b111111, 3'd2, 8'h01, 8'h80, 8'h7F};
    vecs[7] = '{32'h07FEDCBA, 4, 3, 6'b111111, 3'd3, 8'hFE, 8'hDC, 8'hBA};
    vecs[8] = '{32'h0813579B, 4, 0, 6'b111111, 3'd4, 8'h13, 8'h57, 8'h9B};

    rst_n = 1'b0;
    clear_prog();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_flags", flags, 0);
    chk("rst_i", {i1, i2, i3}, 0);
    chk("rst_alu", alu_op, 0);
    chk("rst_status", {exec_valid, halted, illegal}, 0);

    for (int v = 0; v < 9; v++) begin
      logic [31:0] w;
      clear_prog();
      w = vecs[v].bytes;
      for (int k = 0; k < vecs[v].len; k++) prog[k] = w[31-8*k -: 8];
      wait_n = vecs[v].wn;
      push(vecs[v].fl, vecs[v].alu, vecs[v].a1, vecs[v].a2, vecs[v].a3, 8'(vecs[v].len), 1'b0);
      push(6'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'(vecs[v].len + 1), 1'b0);
      do_reset();
      wait_halt("vec");
      chk("vec_illegal", illegal, 0);
      chk("vec_final_pc", mem_addr, vecs[v].len + 1);
      chk("vec_sb_empty", sb.size(), 0);
    end

    // LDI latency with mem_ready tied high: three handshakes then EXEC.
    clear_prog();
    prog[0] = 8'h01; prog[1] = 8'h03; prog[2] = 8'h5A;
    wait_n = 0;
    push(6'b010100, 3'd0, 8'h03, 8'h5A, 8'h00, 8'h03, 1'b0);
    push(6'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h04, 1'b0);
    rst_n = 1'b0;
    release_reset();
    begin
      int n = 0;
      while (!exec_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("ldi_latency", n, 3);
      @(posedge clk); #1;
      chk("ldi_exec_one_cycle", exec_valid, 0);
    end
    wait_halt("ldi");

    // JMP straddling the PC wrap.
    clear_prog();
    prog[8'h00] = 8'h09; prog[8'h01] = 8'hFE;
    prog[8'hFE] = 8'h09; prog[8'hFF] = 8'h10;
    wait_n = 1;
    push(6'b0, 3'd0, 8'hFE, 8'h00, 8'h00, 8'h02, 1'b0);
    push(6'b0, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
    push(6'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h11, 1'b0);
    do_reset();
    wait_halt("jmp");
    chk("jmp_final_pc", mem_addr, 8'h11);
    chk("jmp_sb_empty", sb.size(), 0);

    // Illegal opcode halts and then ignores the bus.
    clear_prog();
    prog[0] = 8'h7E; prog[1] = 8'h00;
    wait_n = 0;
    push(6'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    do_reset();
    wait_halt("illegal");
    chk("ill_sticky", illegal, 1);
    force_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("ill_rd_low", mem_rd, 0);
    chk("ill_pc_frozen", mem_addr, 8'h01);
    chk("ill_still_halted", {halted, illegal}, 2'b11);
    chk("ill_sb_empty", sb.size(), 0);
    force_ready = 1'b0;

    // Asynchronous reset in the middle of an ADDI argument fetch.
    clear_prog();
    prog[0] = 8'h04; prog[1] = 8'h11; prog[2] = 8'h22; prog[3] = 8'h33;
    wait_n = 0;
    do_reset();
    repeat (2) @(posedge clk);
    #3;
    chk("mid_i1_loaded", i1, 8'h11);
    chk("mid_in_fetch", {mem_rd, mem_addr}, {1'b1, 8'h02});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", mem_rd, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_i", {i1, i2, i3}, 0);
    chk("mid_rst_flags", {flags, exec_valid}, 0);
    clear_prog();
    prog[0] = 8'h00;
    push(6'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0);
    push(6'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0);
    release_reset();
    #1;
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_rd", mem_rd, 1);
    wait_halt("nop_halt");
    chk("halt_pc", mem_addr, 8'h02);
    chk("halt_not_illegal", illegal, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
